mcdf_formatter: RTL and testbench
=================================

Name: mcdf_formatter

Overview:
- Sits downstream of the MCDF arbiter and sequences it.
- Issues ID requests to the arbiter and acknowledges the data words it receives.
- Buffers one complete packet whose length is set by the arbiter's package-length select.
- Hands the packet to the external consumer through a request/grant handshake, framed with channel ID, length, start and end markers.

Parameters:
- DATA_W, 32, width of the data words.
- MAX_LEN, 32, packet buffer depth in words; must be >= 32.

Ports:
- clk_i  input  1  system clock, all logic on the rising edge
- rst_i  input  1  synchronous, active-high reset
- a2f_val_i  input  1  arbiter data word valid
- a2f_id_i  input  2  channel ID of the current arbiter word
- a2f_data_i  input  DATA_W  arbiter data word
- a2f_pkglen_sel_i  input  3  package length select
- f2a_id_req_o  output  1  request for a new packet from the arbiter
- f2a_ack_o  output  1  word accepted this cycle
- fmt_req_o  output  1  packet ready, requesting consumer grant
- fmt_grant_i  input  1  consumer grant
- fmt_chid_o  output  2  channel ID of the packet
- fmt_length_o  output  6  packet length in words
- fmt_data_o  output  DATA_W  packet data word
- fmt_start_o  output  1  first word of the packet
- fmt_end_o  output  1  last word of the packet

Behaviour:
- Reset: the clock and reset are one clock, clk_i, with a synchronous active-high reset, rst_i.
  - rst_i sampled high puts the FSM in REQ, clears the word counters and discards buffered data.
  - The cycle after reset, all registered outputs are 0: fmt_req_o, fmt_chid_o, fmt_length_o, fmt_data_o, fmt_start_o, fmt_end_o.
  - f2a_id_req_o is 0 while rst_i is high, and 1 in the first cycle with rst_i low.
  - f2a_ack_o is 0 while rst_i is high.
- Length decode (a2f_pkglen_sel_i to words): 0→4, 1→8, 2→16, 3→32, 4..7→32.
- FSM states: REQ, RECV, WAIT_GRANT, SEND.
- REQ:
  - f2a_id_req_o = 1.
  - f2a_ack_o = a2f_val_i (combinational).
  - On an accepted word, latch a2f_id_i, the decoded length and word 0, then go to RECV. If the length decodes to 1 word (unreachable), go directly to WAIT_GRANT.
- RECV:
  - f2a_id_req_o = 0.
  - f2a_ack_o = a2f_val_i (combinational).
  - Each accepted word is written at the next buffer index.
  - a2f_id_i and a2f_pkglen_sel_i are ignored after the first word.
  - Gaps with a2f_val_i low are allowed, with no timeout.
  - When the word whose count equals the latched length is accepted, go to WAIT_GRANT.
- WAIT_GRANT:
  - f2a_ack_o = 0.
  - fmt_req_o = 1, with fmt_chid_o and fmt_length_o stable.
  - When fmt_grant_i is sampled high, go to SEND. fmt_req_o = 0 from the next cycle.
  - fmt_grant_i is ignored in all other states.
- SEND:
  - One word per cycle on fmt_data_o, in buffer order, with no stalls.
  - fmt_start_o is high with word 0 only; fmt_end_o is high with the last word only. Both are high together only when the length is 1.
  - The cycle after the last word, go to REQ: f2a_id_req_o = 1, fmt_data_o = 0, start/end = 0.
- fmt_chid_o and fmt_length_o:
  - Valid from entry into WAIT_GRANT through the last SEND word.
  - 0 in REQ and RECV.
- Timing example, first word acked at cycle t with length L:
  - f2a_id_req_o is 0 at t+1.
  - fmt_req_o is 1 at t+L, provided all words arrive back-to-back.
  - With grant sampled at cycle g: fmt_start_o at g+1, fmt_end_o at g+L, f2a_id_req_o back to 1 at g+L+1.
- Buffer: the write index never exceeds length-1, so there is no overflow path. Only one packet is in flight; receive and send never overlap.
- Reset mid-operation (any state): the rules above apply in the next cycle. The partial packet is dropped and nothing is emitted for it.

Test Plan:
- Reset hold 3 cycles, then release → all fmt_* = 0 and f2a_id_req_o = 1 in the first cycle after release; f2a_ack_o = 0 while a2f_val_i = 0.
- Send sel=0, id=1, data 0xA0..0xA3 back-to-back; grant 2 cycles after fmt_req_o:
  - f2a_ack_o high for 4 cycles; fmt_req_o rises the cycle after the 4th ack.
  - fmt_chid_o = 1, fmt_length_o = 4.
  - fmt_data_o = A0,A1,A2,A3, with start on A0 and end on A3.
  - f2a_id_req_o = 1 the following cycle.
- Send sel=3, id=2, 32 words with a2f_val_i low every 3rd cycle; grant delayed 5 cycles:
  - Exactly 32 acks; fmt_length_o = 32.
  - fmt_req_o held all 5 cycles.
  - Output data matches the input order.
- Send sel=6, with id changing 0→2 after the first word → fmt_length_o = 32 and fmt_chid_o = 0.
- Assert rst_i on the 3rd SEND word of an 8-word packet:
  - fmt_data_o, fmt_start_o and fmt_end_o are 0 the next cycle; no fmt_end_o is ever produced for that packet.
  - f2a_id_req_o = 1 the first cycle after release.
  - The next packet is delivered intact.
- Hold fmt_grant_i high permanently, then send two sel=1 packets:
  - Each gets exactly one fmt_req_o cycle and 8 SEND words.
  - One REQ cycle separates the last SEND word from the next acceptable word.

Source files
------------

// File: rtl/mcdf_formatter.sv
`default_nettype none
// ============================================================================
// Module   : mcdf_formatter
// Brief    : Requests packets from the MCDF arbiter, buffers one packet and
//            replays it to the consumer framed with id/length/start/end.
// Revision : 1.0 - initial release
// ============================================================================
module mcdf_formatter #(
    parameter int DATA_W  = 32,
    parameter int MAX_LEN = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              a2f_val_i,
    input  logic [1:0]        a2f_id_i,
    input  logic [DATA_W-1:0] a2f_data_i,
    input  logic [2:0]        a2f_pkglen_sel_i,
    output logic              f2a_id_req_o,
    output logic              f2a_ack_o,
    output logic              fmt_req_o,
    input  logic              fmt_grant_i,
    output logic [1:0]        fmt_chid_o,
    output logic [5:0]        fmt_length_o,
    output logic [DATA_W-1:0] fmt_data_o,
    output logic              fmt_start_o,
    output logic              fmt_end_o
);

    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    typedef enum logic [1:0] {
        REQ        = 2'd0,
        RECV       = 2'd1,
        WAIT_GRANT = 2'd2,
        SEND       = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [5:0]          wr_q, wr_d;
    logic [5:0]          rd_q, rd_d;
    logic [1:0]          id_q, id_d;
    logic [5:0]          len_q, len_d;
    logic                req_q, req_d;
    logic [1:0]          chid_q, chid_d;
    logic [5:0]          flen_q, flen_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                start_q, start_d;
    logic                end_q, end_d;
    logic [DATA_W-1:0]   mem_q [MAX_LEN];
    logic                we;
    logic [IDX_W-1:0]    widx;
    logic [IDX_W-1:0]    ridx;
    logic                ack;
    logic                id_req;
    logic [5:0]          dec_len;

    function automatic logic [5:0] decode_len(input logic [2:0] sel);
        case (sel)
            3'd0:    decode_len = 6'd4;
            3'd1:    decode_len = 6'd8;
            3'd2:    decode_len = 6'd16;
            default: decode_len = 6'd32;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        id_d    = id_q;
        len_d   = len_q;
        req_d   = req_q;
        chid_d  = chid_q;
        flen_d  = flen_q;
        data_d  = data_q;
        start_d = start_q;
        end_d   = end_q;
        we      = 1'b0;
        widx    = IDX_W'(wr_q);
        ridx    = (state_q == SEND) ? IDX_W'(rd_q) : '0;
        ack     = 1'b0;
        id_req  = 1'b0;
        dec_len = decode_len(a2f_pkglen_sel_i);
        case (state_q)
            REQ: begin
                id_req = 1'b1;
                ack    = a2f_val_i;
                if (a2f_val_i) begin
                    we    = 1'b1;
                    widx  = '0;
                    id_d  = a2f_id_i;
                    len_d = dec_len;
                    wr_d  = 6'd1;
                    if (dec_len == 6'd1) begin
                        state_d = WAIT_GRANT;
                        req_d   = 1'b1;
                        chid_d  = a2f_id_i;
                        flen_d  = dec_len;
                    end else begin
                        state_d = RECV;
                    end
                end
            end
            RECV: begin
                ack = a2f_val_i;
                if (a2f_val_i) begin
                    we   = 1'b1;
                    wr_d = wr_q + 6'd1;
                    if ((wr_q + 6'd1) == len_q) begin
                        state_d = WAIT_GRANT;
                        req_d   = 1'b1;
                        chid_d  = id_q;
                        flen_d  = len_q;
                    end
                end
            end
            WAIT_GRANT: begin
                if (fmt_grant_i) begin
                    state_d = SEND;
                    req_d   = 1'b0;
                    data_d  = mem_q[ridx];
                    start_d = 1'b1;
                    end_d   = (len_q == 6'd1);
                    rd_d    = 6'd1;
                end
            end
            SEND: begin
                // end_q marks the last word already on the bus; leave next edge
                if (end_q) begin
                    state_d = REQ;
                    data_d  = '0;
                    start_d = 1'b0;
                    end_d   = 1'b0;
                    chid_d  = '0;
                    flen_d  = '0;
                    wr_d    = '0;
                    rd_d    = '0;
                end else begin
                    data_d  = mem_q[ridx];
                    start_d = 1'b0;
                    end_d   = (rd_q == (len_q - 6'd1));
                    rd_d    = rd_q + 6'd1;
                end
            end
            default: state_d = REQ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= REQ;
            wr_q    <= '0;
            rd_q    <= '0;
            id_q    <= '0;
            len_q   <= '0;
            req_q   <= 1'b0;
            chid_q  <= '0;
            flen_q  <= '0;
            data_q  <= '0;
            start_q <= 1'b0;
            end_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            id_q    <= id_d;
            len_q   <= len_d;
            req_q   <= req_d;
            chid_q  <= chid_d;
            flen_q  <= flen_d;
            data_q  <= data_d;
            start_q <= start_d;
            end_q   <= end_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (we && !rst_i) begin
            mem_q[widx] <= a2f_data_i;
        end
    end

    assign f2a_id_req_o = id_req & ~rst_i;
    assign f2a_ack_o    = ack & ~rst_i;
    assign fmt_req_o    = req_q;
    assign fmt_chid_o   = chid_q;
    assign fmt_length_o = flen_q;
    assign fmt_data_o   = data_q;
    assign fmt_start_o  = start_q;
    assign fmt_end_o    = end_q;

endmodule
`default_nettype wire

// File: tb/tb_mcdf_formatter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mcdf_formatter
// Brief    : Scoreboard bench for mcdf_formatter receive, grant and replay.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mcdf_formatter;

    localparam int DATA_W = 32;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              a2f_val_i;
    logic [1:0]        a2f_id_i;
    logic [DATA_W-1:0] a2f_data_i;
    logic [2:0]        a2f_pkglen_sel_i;
    logic              f2a_id_req_o;
    logic              f2a_ack_o;
    logic              fmt_req_o;
    logic              fmt_grant_i;
    logic [1:0]        fmt_chid_o;
    logic [5:0]        fmt_length_o;
    logic [DATA_W-1:0] fmt_data_o;
    logic              fmt_start_o;
    logic              fmt_end_o;

    int checks   = 0;
    int failures = 0;
    logic [DATA_W-1:0] exp_q [$];

    mcdf_formatter #(.DATA_W(DATA_W), .MAX_LEN(32)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .a2f_val_i        (a2f_val_i),
        .a2f_id_i         (a2f_id_i),
        .a2f_data_i       (a2f_data_i),
        .a2f_pkglen_sel_i (a2f_pkglen_sel_i),
        .f2a_id_req_o     (f2a_id_req_o),
        .f2a_ack_o        (f2a_ack_o),
        .fmt_req_o        (fmt_req_o),
        .fmt_grant_i      (fmt_grant_i),
        .fmt_chid_o       (fmt_chid_o),
        .fmt_length_o     (fmt_length_o),
        .fmt_data_o       (fmt_data_o),
        .fmt_start_o      (fmt_start_o),
        .fmt_end_o        (fmt_end_o)
    );

    always #5 clk_i = ~clk_i;

    // Drives one packet word by word; accepted words go to the scoreboard.
    // Ends in the cycle after the last ack, where fmt_req_o must be high.
    task automatic send_pkt(input logic [1:0] id, input logic [2:0] sel, input int len,
                            input bit gaps, input bit id_change, input logic [31:0] base);
        int acked = 0;
        int c = 0;
        while (acked < len && c < len * 4 + 16) begin
            @(negedge clk_i);
            a2f_val_i        = !(gaps && (c % 3 == 2));
            a2f_id_i         = (id_change && acked > 0) ? 2'd2 : id;
            a2f_pkglen_sel_i = (acked > 0) ? 3'(c) : sel;
            a2f_data_i       = base + 32'(acked);
            #1;
            checks++;
            if (f2a_ack_o !== a2f_val_i)
                $display("FAIL ack_follow: got %b expected %b (word %0d)", f2a_ack_o, a2f_val_i, acked);
            checks++;
            if (acked == 0) begin
                if ({f2a_id_req_o, fmt_req_o, fmt_start_o, fmt_end_o, fmt_chid_o, fmt_length_o, fmt_data_o}
                    !== {1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 6'd0, {DATA_W{1'b0}}}) begin
                    failures++;
                    $display("FAIL req_state_outputs: got id_req=%b req=%b st=%b en=%b ch=%0d len=%0d data=%h expected id_req=1 rest 0",
                             f2a_id_req_o, fmt_req_o, fmt_start_o, fmt_end_o, fmt_chid_o, fmt_length_o, fmt_data_o);
                end
            end else if ({f2a_id_req_o, fmt_req_o} !== 2'b00) begin
                failures++;
                $display("FAIL recv_outputs: got id_req=%b req=%b expected 0 0", f2a_id_req_o, fmt_req_o);
            end
            if (f2a_ack_o !== a2f_val_i) failures++;
            if (a2f_val_i && f2a_ack_o) begin
                exp_q.push_back(a2f_data_i);
                acked++;
            end
            c++;
        end
        checks++;
        if (acked < len) begin
            failures++;
            $display("FAIL recv_timeout: got %0d acks expected %0d", acked, len);
        end
        @(negedge clk_i);
        a2f_val_i  = 1'b1;
        a2f_data_i = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (f2a_ack_o !== 1'b0) begin
            failures++;
            $display("FAIL extra_ack: got %b expected 0", f2a_ack_o);
        end
        checks++;
        if ({fmt_req_o, fmt_chid_o, fmt_length_o} !== {1'b1, id, 6'(len)}) begin
            failures++;
            $display("FAIL req_rise: got req=%b ch=%0d len=%0d expected req=1 ch=%0d len=%0d",
                     fmt_req_o, fmt_chid_o, fmt_length_o, id, len);
        end
    endtask

    // Keeps grant low until cycle W0+delay (W0 = first fmt_req_o cycle).
    task automatic wait_grant(input int delay, input logic [1:0] id, input int len);
        for (int d = 1; d <= delay; d++) begin
            @(negedge clk_i);
            a2f_val_i   = 1'b0;
            fmt_grant_i = (d == delay);
            #1;
            checks++;
            if ({fmt_req_o, fmt_chid_o, fmt_length_o} !== {1'b1, id, 6'(len)}) begin
                failures++;
                $display("FAIL req_hold: got req=%b ch=%0d len=%0d expected req=1 ch=%0d len=%0d (cycle %0d)",
                         fmt_req_o, fmt_chid_o, fmt_length_o, id, len, d);
            end
        end
    endtask

    task automatic collect(input logic [1:0] id, input int len, input int stop_at, input bit hold);
        logic [DATA_W-1:0] exp;
        for (int k = 0; k < stop_at; k++) begin
            @(negedge clk_i);
            fmt_grant_i = hold;
            a2f_val_i   = 1'b0;
            #1;
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hBAD0_0000;
            checks++;
            if (fmt_data_o !== exp) begin
                failures++;
                $display("FAIL send_data: got %h expected %h (word %0d)", fmt_data_o, exp, k);
            end
            checks++;
            if ({fmt_req_o, fmt_start_o, fmt_end_o, fmt_chid_o, fmt_length_o}
                !== {1'b0, (k == 0), (k == len - 1), id, 6'(len)}) begin
                failures++;
                $display("FAIL send_frame: got req=%b st=%b en=%b ch=%0d len=%0d expected req=0 st=%b en=%b ch=%0d len=%0d (word %0d)",
                         fmt_req_o, fmt_start_o, fmt_end_o, fmt_chid_o, fmt_length_o,
                         (k == 0), (k == len - 1), id, len, k);
            end
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            a2f_val_i = 1'b1;
            #1;
            if (i > 0) begin
                checks++;
                if ({f2a_id_req_o, f2a_ack_o} !== 2'b00) begin
                    failures++;
                    $display("FAIL reset_hold: got id_req=%b ack=%b expected 0 0", f2a_id_req_o, f2a_ack_o);
                end
            end
        end
        @(negedge clk_i);
        rst_i     = 1'b0;
        a2f_val_i = 1'b0;
        #1;
        checks++;
        if ({f2a_id_req_o, f2a_ack_o, fmt_req_o, fmt_start_o, fmt_end_o, fmt_chid_o, fmt_length_o, fmt_data_o}
            !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 6'd0, {DATA_W{1'b0}}}) begin
            failures++;
            $display("FAIL reset_release: got id_req=%b ack=%b req=%b st=%b en=%b ch=%0d len=%0d data=%h expected id_req=1 rest 0",
                     f2a_id_req_o, f2a_ack_o, fmt_req_o, fmt_start_o, fmt_end_o, fmt_chid_o, fmt_length_o, fmt_data_o);
        end
    endtask

    task automatic test_basic();
        send_pkt(2'd1, 3'd0, 4, 1'b0, 1'b0, 32'hA0);
        wait_grant(2, 2'd1, 4);
        collect(2'd1, 4, 4, 1'b0);
    endtask

    task automatic test_gaps();
        send_pkt(2'd2, 3'd3, 32, 1'b1, 1'b0, 32'h1000);
        wait_grant(5, 2'd2, 32);
        collect(2'd2, 32, 32, 1'b0);
    endtask

    task automatic test_sel_clamp();
        send_pkt(2'd0, 3'd6, 32, 1'b0, 1'b1, 32'h5500);
        wait_grant(1, 2'd0, 32);
        collect(2'd0, 32, 32, 1'b0);
    endtask

    task automatic test_reset_mid_send();
        send_pkt(2'd3, 3'd1, 8, 1'b0, 1'b0, 32'h7700);
        wait_grant(1, 2'd3, 8);
        collect(2'd3, 8, 3, 1'b0);
        rst_i = 1'b1;
        @(negedge clk_i);
        a2f_val_i = 1'b1;
        #1;
        checks++;
        if ({fmt_data_o, fmt_start_o, fmt_end_o, f2a_id_req_o, f2a_ack_o} !== {{DATA_W{1'b0}}, 4'b0000}) begin
            failures++;
            $display("FAIL mid_reset_clear: got data=%h st=%b en=%b id_req=%b ack=%b expected all 0",
                     fmt_data_o, fmt_start_o, fmt_end_o, f2a_id_req_o, f2a_ack_o);
        end
        rst_i     = 1'b0;
        a2f_val_i = 1'b0;
        #1;
        checks++;
        if (f2a_id_req_o !== 1'b1) begin
            failures++;
            $display("FAIL mid_reset_release: got id_req=%b expected 1", f2a_id_req_o);
        end
        exp_q.delete();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            #1;
            checks++;
            if ({fmt_end_o, fmt_req_o} !== 2'b00) begin
                failures++;
                $display("FAIL dropped_pkt_emitted: got end=%b req=%b expected 0 0", fmt_end_o, fmt_req_o);
            end
        end
        send_pkt(2'd1, 3'd1, 8, 1'b0, 1'b0, 32'h8800);
        wait_grant(3, 2'd1, 8);
        collect(2'd1, 8, 8, 1'b0);
    endtask

    task automatic test_back_to_back();
        fmt_grant_i = 1'b1;
        send_pkt(2'd2, 3'd1, 8, 1'b0, 1'b0, 32'hB000);
        collect(2'd2, 8, 8, 1'b1);
        send_pkt(2'd3, 3'd1, 8, 1'b0, 1'b0, 32'hC000);
        collect(2'd3, 8, 8, 1'b1);
        @(negedge clk_i);
        fmt_grant_i = 1'b0;
        #1;
        checks++;
        if ({f2a_id_req_o, fmt_data_o, fmt_start_o, fmt_end_o} !== {1'b1, {DATA_W{1'b0}}, 2'b00}) begin
            failures++;
            $display("FAIL post_send_req: got id_req=%b data=%h st=%b en=%b expected 1 0 0 0",
                     f2a_id_req_o, fmt_data_o, fmt_start_o, fmt_end_o);
        end
    endtask

    initial begin
        rst_i            = 1'b1;
        a2f_val_i        = 1'b0;
        a2f_id_i         = '0;
        a2f_data_i       = '0;
        a2f_pkglen_sel_i = '0;
        fmt_grant_i      = 1'b0;
        test_reset();
        test_basic();
        test_gaps();
        test_sel_clamp();
        test_reset_mid_send();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
